// File: rtl/robo_if.sv
// Sensor and command bundle between the robo controller and its environment model.
interface robo_if;
  logic       head;
  logic       left;
  logic       under;
  logic       barrier;
  logic       avancar;
  logic       girar;
  logic       remover;
  logic [2:0] dbg_state;

  // No handshake: sensors are level signals sampled every rising edge,
  // commands are one-cycle registered pulses the plant acts on before the next edge.
  modport slave (
    input  head, left, under, barrier,
    output avancar, girar, remover, dbg_state
  );

  modport master (
    output head, left, under, barrier,
    input  avancar, girar, remover, dbg_state
  );
endinterface

// File: rtl/robo.sv
// Left-hand wall-following maze controller with registered one-hot motion commands.
// Define ROBO_REMOVE_EN to enable debris removal (REMOVE state and remover output).
module robo (
  input  logic  clock,
  input  logic  reset,
  robo_if.slave bus
);

`ifdef ROBO_REMOVE_EN
  typedef enum logic [2:0] {SEEK, FOLLOW, FWD, RIGHT, REMOVE, DONE} state_t;
`else
  typedef enum logic [2:0] {SEEK, FOLLOW, FWD, RIGHT, DONE} state_t;
`endif

  typedef struct packed {
    logic       adv;
    logic       gir;
    logic       rem;
    state_t     nxt;
    logic [1:0] cnt;
  } decision_t;

  state_t     state;
  logic [1:0] count;
  logic       departed;
  logic       cmd_adv;
  logic       cmd_gir;
  logic       cmd_rem;
  logic       blocked;
  logic       debris;
  decision_t  dec;

  // Without removal, debris is just another wall.
`ifdef ROBO_REMOVE_EN
  assign blocked = bus.head;
  assign debris  = !bus.head && bus.barrier;
`else
  assign blocked = bus.head || bus.barrier;
  assign debris  = 1'b0;
`endif

  function automatic decision_t follow_rule(input logic l, input logic blk, input logic deb);
    decision_t d;
    d     = '0;
    d.nxt = FOLLOW;
    if (!l) begin
      d.gir = 1'b1;
      d.nxt = FWD;
    end else if (blk) begin
      d.gir = 1'b1;
      d.nxt = RIGHT;
      d.cnt = 2'd1;
    end else if (deb) begin
`ifdef ROBO_REMOVE_EN
      d.rem = 1'b1;
      d.nxt = REMOVE;
`endif
    end else begin
      d.adv = 1'b1;
    end
    return d;
  endfunction

  always_comb begin
    dec     = '0;
    dec.nxt = state;
    if (state != DONE && bus.under && departed) begin
      dec.nxt = DONE;
    end else begin
      case (state)
        SEEK: begin
          if (bus.left) begin
            dec = follow_rule(bus.left, blocked, debris);
          end else if (blocked) begin
            dec.gir = 1'b1;
            dec.nxt = RIGHT;
            dec.cnt = 2'd1;
          end else if (debris) begin
`ifdef ROBO_REMOVE_EN
            dec.nxt = REMOVE;
`endif
          end else begin
            dec.adv = 1'b1;
          end
        end
        FOLLOW: dec = follow_rule(bus.left, blocked, debris);
        FWD: begin
          // Left sensor ignored on an open cell so the robot does not spin in place.
          if (blocked) begin
            dec = follow_rule(bus.left, blocked, debris);
          end else if (debris) begin
`ifdef ROBO_REMOVE_EN
            dec.rem = 1'b1;
            dec.nxt = REMOVE;
`endif
          end else begin
            dec.adv = 1'b1;
            dec.nxt = FOLLOW;
          end
        end
        RIGHT: begin
          dec.gir = 1'b1;
          if (count == 2'd2) begin
            dec.nxt = FOLLOW;
          end else begin
            dec.cnt = count + 2'd1;
          end
        end
`ifdef ROBO_REMOVE_EN
        REMOVE: begin
          if (bus.head) begin
            dec.nxt = FOLLOW;
          end else if (bus.barrier) begin
            dec.rem = 1'b1;
          end else begin
            dec.adv = 1'b1;
            dec.nxt = FOLLOW;
          end
        end
`endif
        DONE:    dec.nxt = DONE;
        default: dec.nxt = SEEK;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= SEEK;
      count    <= 2'd0;
      departed <= 1'b0;
      cmd_adv  <= 1'b0;
      cmd_gir  <= 1'b0;
      cmd_rem  <= 1'b0;
    end else begin
      state    <= dec.nxt;
      count    <= dec.cnt;
      departed <= departed || dec.adv;
      cmd_adv  <= dec.adv;
      cmd_gir  <= dec.gir;
      cmd_rem  <= dec.rem;
    end
  end

  assign bus.avancar   = cmd_adv;
  assign bus.girar     = cmd_gir;
  assign bus.remover   = cmd_rem;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_robo.sv
// Directed bench for robo: commands compared as {avancar, girar, remover}.
module tb_robo;
  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] ADV  = 3'b100;
  localparam logic [2:0] GIR  = 3'b010;
  localparam logic [2:0] REM  = 3'b001;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  robo_if bus();

  robo dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic drive(input logic l, input logic h, input logic b, input logic u);
    bus.left    = l;
    bus.head    = h;
    bus.barrier = b;
    bus.under   = u;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] cmd();
    return {bus.avancar, bus.girar, bus.remover};
  endfunction

  // checker
  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // reset held two cycles
    tick();
    tick();
    check("reset_idle", cmd(), NONE);

    // release with a wall on the left: follow rule straight away
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("release_adv", cmd(), ADV);

    // restart in SEEK, open field
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("seek_adv%0d", i), cmd(), ADV);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("seek_turn%0d", i), cmd(), GIR);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("after_right_adv", cmd(), ADV);

    // left opening: one girar, then advance despite left still open
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("open_left_gir", cmd(), GIR);
    tick();
    check("fwd_adv", cmd(), ADV);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("follow_adv", cmd(), ADV);

    // corner: exactly three turns, then the next decision
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("corner_turn%0d", i), cmd(), GIR);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("corner_next", cmd(), ADV);

    // debris ahead
    drive(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef ROBO_REMOVE_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("debris_rem%0d", i), cmd(), REM);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("debris_clear_adv", cmd(), ADV);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("debris2_rem", cmd(), REM);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("remove_head_idle", cmd(), NONE);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("remove_exit_adv", cmd(), ADV);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("debris_turn%0d", i), cmd(), GIR);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("debris_next_adv", cmd(), ADV);
`endif

    // asynchronous reset mid-command
    tick();
    check("pre_reset_adv", cmd(), ADV);
    #3 reset = 1'b1;
    #1 check("async_reset_idle", cmd(), NONE);
    tick();
    check("reset_held_idle", cmd(), NONE);

    // under=1 at start is ignored until the first advance
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("start_under_ignored", cmd(), ADV);
    tick();
    check("home_halt", cmd(), NONE);

    // DONE holds regardless of sensors
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      check($sformatf("done_hold%0d", i), cmd(), NONE);
    end

    // reset leaves DONE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("after_done_reset_adv", cmd(), ADV);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
